mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, fixed-latency unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the MIPS pipeline. The block grants the port, with MEM taking priority, and sequences each access through a small issue/wait state machine. It registers the returned data and drives a global `stall` that freezes the pipeline until every pending request of the current pipeline cycle has completed. It sits between the IF/MEM stages, the hazard/flush logic and the memory macro.

## Interface
Parameters:
- `LATENCY`, default 2: cycles from the issue cycle to the cycle in which `mRdata` is valid. Minimum 1.

Ports:
- `clk`  input  1  clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `iReq`  input  1  IF requests an instruction read; held until `stall` drops
- `iAddr`  input  32  fetch address
- `iFlush`  input  1  cancel the current fetch (branch/jump redirect)
- `dReq`  input  1  MEM requests an access (memRead | memWrite); held until `stall` drops
- `dWrite`  input  1  1 = store, 0 = load; qualified by `dReq`
- `dAddr`  input  32  data address
- `dWdata`  input  32  store data
- `mRdata`  input  32  memory read data
- `mAddr`  output  32  memory address
- `mWdata`  output  32  memory write data
- `mRe`  output  1  memory read strobe, one cycle
- `mWe`  output  1  memory write strobe, one cycle
- `iRdata`  output  32  registered instruction word
- `iValid`  output  1  one-cycle pulse when `iRdata` is updated
- `dRdata`  output  32  registered load data
- `dValid`  output  1  one-cycle pulse when a data access completes (loads and stores)
- `stall`  output  1  freeze the pipeline

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY_I: instruction access in flight.
  - BUSY_D: data access in flight.
- Sticky flags `iDone` and `dDone` record that a request has been served in the current pipeline cycle.
- `stall` = (`iReq` & ~`iDone`) | (`dReq` & ~`dDone`). It is combinational from registers and inputs.
- Any clock edge with `stall` = 0 clears both `iDone` and `dDone`, because the pipeline advances on that edge.
- In IDLE:
  - If `dReq` & ~`dDone`, issue D: drive `mAddr`=`dAddr`, `mWdata`=`dWdata`, and `mWe`=`dWrite`, `mRe`=~`dWrite` for this cycle only. Load counter = `LATENCY`, go to BUSY_D.
  - Else if `iReq` & ~`iDone` & ~`iFlush`, issue an I read the same way (`mRe`=1) and go to BUSY_I.
  - MEM always wins over IF. Starvation is impossible because `dDone` blocks a second D issue until the pipeline advances.
- In BUSY_x, the counter decrements each cycle. In the cycle where the counter equals 1:
  - Capture `mRdata`: into `dRdata` on a D read, into `iRdata` on an I read. Stores do not update `dRdata`.
  - Set `xDone`, pulse `xValid` in the next cycle, and return to IDLE.
- `mAddr`, `mWdata`, `mRe` and `mWe` are 0 in every cycle that is not an issue cycle.
- Flush:
  - `iFlush` during BUSY_I marks the access as discarded: it completes normally on the port, but `iRdata`, `iValid` and `iDone` are untouched.
  - `iFlush` clears `iDone` in any state.
  - `iFlush` in IDLE suppresses an I issue in that cycle.
- Address and data are latched only at issue. Changes on the inputs during BUSY have no effect.

## Timing
- Issue in cycle T: strobes and `mAddr` are valid in cycle T. `mRdata` is sampled at the edge ending cycle T+`LATENCY`.
- `xValid` and `xRdata` are valid from cycle T+`LATENCY`+1. The flag `xDone` is set at the same time.
- One access occupies the port for `LATENCY`+1 cycles. Back-to-back accesses issue in cycles T and T+`LATENCY`+1.
- Both requests pending with `LATENCY`=2:
  - D issues in cycle 0 and I issues in cycle 3.
  - `stall` is high in cycles 0–5 and low in cycle 6.
- Reset (asynchronous, any time, including mid-access): state IDLE, counter 0, both done flags 0, every output register 0. An in-flight access is abandoned with no valid pulse.
- `stall` may be high in the first cycle after reset if a request is already present.

## Test plan
- Lone load, `LATENCY`=2: `dReq`=1, `dWrite`=0, `dAddr`=0x40 at cycle 0.
  - `mRe`=1 and `mAddr`=0x40 in cycle 0 only.
  - `mRdata`=0xDEADBEEF in cycle 2 gives `dRdata`=0xDEADBEEF and `dValid`=1 in cycle 3.
  - `stall` is 1 in cycles 0–2 and 0 in cycle 3.
- Simultaneous fetch and store: `iReq` with `iAddr`=0x100, plus a store to 0x200 with data 0x1234.
  - `mWe`, `mAddr`=0x200 and `mWdata`=0x1234 in cycle 0.
  - `mRe` with `mAddr`=0x100 in cycle 3.
  - `dValid` in cycle 3 and `iValid` in cycle 6. `dRdata` is unchanged.
- Held request after service: keep `dReq` high through completion while `iReq` is pending.
  - There is no second D issue; I issues next.
  - Both flags clear after the `stall`=0 edge.
  - A new `dReq` in the following pipeline cycle issues again.
- Flush in flight: `iFlush` pulse in cycle 1 of an I access.
  - `mRe` still occurs only once.
  - No `iValid`, `iRdata` is unchanged, and `stall` stays high until a re-fetch (new `iReq`) completes.
- Reset mid-access: assert `rst`=0 in cycle 1 of a D load.
  - All outputs read 0 immediately and there is no `dValid`.
  - After release with `dReq` held, a fresh issue occurs in the first cycle.
- `LATENCY`=1 sweep: alternating I/D requests.
  - Accesses issue every 2 cycles.
  - Data matches a memory model for 1000 random accesses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and data access.
// Data access has priority. Per-cycle done flags hold the pipeline stall until every pending request is served.
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  input  logic        iFlush,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [31:0] mRdata,
  output logic [31:0] mAddr,
  output logic [31:0] mWdata,
  output logic        mRe,
  output logic        mWe,
  output logic [31:0] iRdata,
  output logic        iValid,
  output logic [31:0] dRdata,
  output logic        dValid,
  output logic        stall
);

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic          wr_q, wr_d;
  logic          drop_q, drop_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          i_valid_q, i_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          issue_d, issue_i, last;

  // Strobes and stall are gated by reset so every output reads 0 while it is held.
  assign issue_d = rst && (state_q == IDLE) && dReq && !d_done_q;
  assign issue_i = rst && (state_q == IDLE) && !issue_d && iReq && !i_done_q && !iFlush;
  assign last    = (state_q != IDLE) && (cnt_q == CW'(1));
  assign stall   = rst && ((iReq && !i_done_q) || (dReq && !d_done_q));

  assign mAddr  = issue_d ? dAddr : (issue_i ? iAddr : 32'd0);
  assign mWdata = issue_d ? dWdata : 32'd0;
  assign mWe    = issue_d && dWrite;
  assign mRe    = issue_i || (issue_d && !dWrite);

  assign iRdata = i_rdata_q;
  assign iValid = i_valid_q;
  assign dRdata = d_rdata_q;
  assign dValid = d_valid_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    drop_d    = drop_q;
    i_done_d  = i_done_q;
    d_done_d  = d_done_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;

    if (!stall) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end

    if (issue_d) begin
      state_d = BUSY_D;
      cnt_d   = CW'(LATENCY);
      wr_d    = dWrite;
    end else if (issue_i) begin
      state_d = BUSY_I;
      cnt_d   = CW'(LATENCY);
      drop_d  = 1'b0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - CW'(1);
      if (last) begin
        state_d = IDLE;
        if (state_q == BUSY_D) begin
          d_done_d  = 1'b1;
          d_valid_d = 1'b1;
          if (!wr_q) d_rdata_d = mRdata;
        end else if (!(drop_q || iFlush)) begin
          i_done_d  = 1'b1;
          i_valid_d = 1'b1;
          i_rdata_d = mRdata;
        end
      end
    end

    // A redirected fetch still occupies the port but its result is thrown away.
    if ((state_q == BUSY_I) && iFlush) drop_d = 1'b1;
    if (iFlush) i_done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      drop_q    <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      drop_q    <= drop_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios at LATENCY=2 and an alternating I/D sweep at LATENCY=1.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iReq, iFlush, dReq, dWrite;
  logic [31:0] iAddr, dAddr, dWdata, mRdata, mAddr, mWdata, iRdata, dRdata;
  logic        mRe, mWe, iValid, dValid, stall;

  logic        iReq1, iFlush1, dReq1, dWrite1;
  logic [31:0] iAddr1, dAddr1, dWdata1, mRdata1, mAddr1, mWdata1, iRdata1, dRdata1;
  logic        mRe1, mWe1, iValid1, dValid1, stall1;

  mem_port_arbiter #(.LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .iReq(iReq), .iAddr(iAddr), .iFlush(iFlush),
    .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWdata(dWdata), .mRdata(mRdata),
    .mAddr(mAddr), .mWdata(mWdata), .mRe(mRe), .mWe(mWe),
    .iRdata(iRdata), .iValid(iValid), .dRdata(dRdata), .dValid(dValid), .stall(stall)
  );

  mem_port_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .iReq(iReq1), .iAddr(iAddr1), .iFlush(iFlush1),
    .dReq(dReq1), .dWrite(dWrite1), .dAddr(dAddr1), .dWdata(dWdata1), .mRdata(mRdata1),
    .mAddr(mAddr1), .mWdata(mWdata1), .mRe(mRe1), .mWe(mWe1),
    .iRdata(iRdata1), .iValid(iValid1), .dRdata(dRdata1), .dValid(dValid1), .stall(stall1)
  );

  // Memory macros: read address captured on the read strobe, data visible from the next cycle.
  logic [31:0] mem2 [256];
  logic [7:0]  ra2;
  logic [31:0] mem1 [16];
  logic [3:0]  ra1;

  always @(posedge clk) begin
    if (mRe) ra2 <= mAddr[9:2];
    if (mWe) mem2[mAddr[9:2]] <= mWdata;
    if (mRe1) ra1 <= mAddr1[5:2];
    if (mWe1) mem1[mAddr1[5:2]] <= mWdata1;
  end
  assign mRdata  = mem2[ra2];
  assign mRdata1 = mem1[ra1];

  int checks = 0;
  int passes = 0;

  logic [65:0] exp_iss[$];
  logic [31:0] exp_d[$], exp_i[$], exp_d1[$], exp_i1[$];
  logic [31:0] ref_mem [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  task automatic unexpected(input string name);
    checks++;
    $display("FAIL %s: got pulse=1 required no pending expectation", name);
  endtask

  function automatic logic [65:0] iss(input logic re, input logic we,
                                      input logic [31:0] a, input logic [31:0] wd);
    return {re, we, a, wd};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a strobe or a valid pulse.
  always @(negedge clk) begin
    logic [65:0] e;
    if (mRe || mWe) begin
      if (exp_iss.size() == 0) unexpected("issue");
      else begin
        e = exp_iss.pop_front();
        chk("iss_re", {31'd0, mRe}, {31'd0, e[65]});
        chk("iss_we", {31'd0, mWe}, {31'd0, e[64]});
        chk("iss_addr", mAddr, e[63:32]);
        chk("iss_wdata", mWdata, e[31:0]);
      end
    end
    if (dValid) begin
      if (exp_d.size() == 0) unexpected("dvalid");
      else chk("drdata", dRdata, exp_d.pop_front());
    end
    if (iValid) begin
      if (exp_i.size() == 0) unexpected("ivalid");
      else chk("irdata", iRdata, exp_i.pop_front());
    end
    if (dValid1) begin
      if (exp_d1.size() == 0) unexpected("dvalid1");
      else chk("sweep_drdata", dRdata1, exp_d1.pop_front());
    end
    if (iValid1) begin
      if (exp_i1.size() == 0) unexpected("ivalid1");
      else chk("sweep_irdata", iRdata1, exp_i1.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded bound", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  di, ii;
    logic        w;
    logic [31:0] wd, last_ld;

    rst = 1'b0;
    iReq = 0; iFlush = 0; dReq = 0; dWrite = 0; iAddr = 0; dAddr = 0; dWdata = 0;
    iReq1 = 0; iFlush1 = 0; dReq1 = 0; dWrite1 = 0; iAddr1 = 0; dAddr1 = 0; dWdata1 = 0;
    ra2 = 0; ra1 = 0;
    for (int k = 0; k < 256; k++) mem2[k] = 32'h0;
    for (int k = 0; k < 16; k++) begin
      mem1[k] = $urandom;
      ref_mem[k] = mem1[k];
    end
    mem2[16] = 32'hDEADBEEF;
    mem2[64] = 32'h20080005;
    mem2[65] = 32'h8C090010;
    mem2[66] = 32'h11111111;
    mem2[67] = 32'h22222222;

    cyc(); #1;
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_mre", {31'd0, mRe}, 0);
    chk("rst_dvalid", {31'd0, dValid}, 0);
    chk("rst_drdata", dRdata, 0);
    chk("rst_irdata", iRdata, 0);
    rst = 1'b1;
    cyc();

    // Lone load
    dReq = 1; dWrite = 0; dAddr = 32'h40; dWdata = 0;
    exp_iss.push_back(iss(1, 0, 32'h40, 0)); exp_d.push_back(32'hDEADBEEF);
    #1 chk("t1_stall_c0", {31'd0, stall}, 1); chk("t1_mre_c0", {31'd0, mRe}, 1); chk("t1_maddr_c0", mAddr, 32'h40);
    cyc(); #1 chk("t1_stall_c1", {31'd0, stall}, 1); chk("t1_mre_c1", {31'd0, mRe}, 0); chk("t1_maddr_c1", mAddr, 0);
    cyc(); #1 chk("t1_stall_c2", {31'd0, stall}, 1);
    cyc(); #1 chk("t1_stall_c3", {31'd0, stall}, 0); chk("t1_dvalid_c3", {31'd0, dValid}, 1);
    cyc(); dReq = 0; #1 chk("t1_dvalid_c4", {31'd0, dValid}, 0);
    cyc();

    // Simultaneous fetch and store
    iReq = 1; iAddr = 32'h100; dReq = 1; dWrite = 1; dAddr = 32'h200; dWdata = 32'h1234;
    exp_iss.push_back(iss(0, 1, 32'h200, 32'h1234)); exp_iss.push_back(iss(1, 0, 32'h100, 0));
    exp_d.push_back(32'hDEADBEEF); exp_i.push_back(32'h20080005);
    #1 chk("t2_mwe_c0", {31'd0, mWe}, 1); chk("t2_stall_c0", {31'd0, stall}, 1);
    cyc(); cyc(); cyc();
    #1 chk("t2_mre_c3", {31'd0, mRe}, 1); chk("t2_maddr_c3", mAddr, 32'h100); chk("t2_dvalid_c3", {31'd0, dValid}, 1);
    cyc(); cyc(); #1 chk("t2_stall_c5", {31'd0, stall}, 1);
    cyc(); #1 chk("t2_stall_c6", {31'd0, stall}, 0); chk("t2_ivalid_c6", {31'd0, iValid}, 1);
    cyc(); iReq = 0; dReq = 0; dWrite = 0; dWdata = 0;
    cyc();

    // Held request after service, then a new data request
    dReq = 1; dAddr = 32'h200; iReq = 1; iAddr = 32'h104;
    exp_iss.push_back(iss(1, 0, 32'h200, 0)); exp_iss.push_back(iss(1, 0, 32'h104, 0));
    exp_d.push_back(32'h1234); exp_i.push_back(32'h8C090010);
    cyc(); cyc(); cyc();
    #1 chk("t3_mre_c3", {31'd0, mRe}, 1); chk("t3_maddr_c3", mAddr, 32'h104);
    cyc(); cyc(); cyc(); #1 chk("t3_stall_c6", {31'd0, stall}, 0);
    cyc(); iReq = 0; dAddr = 32'h40;
    exp_iss.push_back(iss(1, 0, 32'h40, 0)); exp_d.push_back(32'hDEADBEEF);
    #1 chk("t3_reissue_c7", {31'd0, mRe}, 1); chk("t3_stall_c7", {31'd0, stall}, 1);
    cyc(); cyc(); cyc(); #1 chk("t3_stall_c10", {31'd0, stall}, 0); chk("t3_dvalid_c10", {31'd0, dValid}, 1);
    cyc(); dReq = 0;
    cyc();

    // Flush in flight
    iReq = 1; iAddr = 32'h108;
    exp_iss.push_back(iss(1, 0, 32'h108, 0));
    cyc(); iFlush = 1; iAddr = 32'h300;
    #1 chk("t4_mre_c1", {31'd0, mRe}, 0); chk("t4_stall_c1", {31'd0, stall}, 1);
    cyc(); iFlush = 0; iAddr = 32'h10C;
    #1 chk("t4_mre_c2", {31'd0, mRe}, 0);
    cyc();
    exp_iss.push_back(iss(1, 0, 32'h10C, 0)); exp_i.push_back(32'h22222222);
    #1 chk("t4_ivalid_c3", {31'd0, iValid}, 0); chk("t4_irdata_c3", iRdata, 32'h8C090010);
    chk("t4_stall_c3", {31'd0, stall}, 1); chk("t4_maddr_c3", mAddr, 32'h10C);
    cyc(); cyc(); #1 chk("t4_stall_c5", {31'd0, stall}, 1);
    cyc(); #1 chk("t4_stall_c6", {31'd0, stall}, 0);
    cyc(); iReq = 0;
    cyc();

    // Reset in the middle of a load
    dReq = 1; dWrite = 0; dAddr = 32'h40;
    exp_iss.push_back(iss(1, 0, 32'h40, 0));
    cyc(); rst = 0;
    #1 chk("t5_mre", {31'd0, mRe}, 0); chk("t5_maddr", mAddr, 0); chk("t5_stall", {31'd0, stall}, 0);
    chk("t5_drdata", dRdata, 0); chk("t5_irdata", iRdata, 0); chk("t5_dvalid", {31'd0, dValid}, 0);
    cyc(); cyc();
    exp_iss.push_back(iss(1, 0, 32'h40, 0)); exp_d.push_back(32'hDEADBEEF);
    rst = 1;
    #1 chk("t5_reissue", {31'd0, mRe}, 1); chk("t5_stall_rel", {31'd0, stall}, 1);
    cyc(); cyc(); cyc(); #1 chk("t5_dvalid_c6", {31'd0, dValid}, 1);
    cyc(); dReq = 0;
    cyc();

    // LATENCY=1 sweep: a D access and an I fetch every pipeline cycle
    last_ld = 32'h0;
    for (int p = 0; p < 500; p++) begin
      di = 4'($urandom_range(0, 15));
      ii = 4'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      dReq1 = 1; dWrite1 = w; dAddr1 = {26'd0, di, 2'b00}; dWdata1 = w ? wd : 32'd0;
      iReq1 = 1; iAddr1 = {26'd0, ii, 2'b00};
      if (w) ref_mem[di] = wd;
      else last_ld = ref_mem[di];
      exp_d1.push_back(last_ld);
      exp_i1.push_back(ref_mem[ii]);
      #1 chk("sw_d_addr", mAddr1, {26'd0, di, 2'b00}); chk("sw_d_we", {31'd0, mWe1}, {31'd0, w});
      cyc(); cyc();
      #1 chk("sw_i_re", {31'd0, mRe1}, 1); chk("sw_i_addr", mAddr1, {26'd0, ii, 2'b00});
      cyc(); cyc();
      #1 chk("sw_stall", {31'd0, stall1}, 0);
      cyc();
    end
    dReq1 = 0; iReq1 = 0;
    cyc(); cyc();

    chk("q_iss_empty", exp_iss.size(), 0);
    chk("q_d_empty", exp_d.size(), 0);
    chk("q_i_empty", exp_i.size(), 0);
    chk("q_d1_empty", exp_d1.size(), 0);
    chk("q_i1_empty", exp_i1.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
